prio_bitscan_enc: RTL and testbench
===================================

Name: prio_bitscan_enc

Overview:
- Parametrised, sequential successor to the team's 8-to-3 priority encoder.
- Accepts an N-bit request vector over a valid/ready handshake and stores it.
- Emits the index of every set bit, one per handshake on the output side.
- Ordering is selectable: fixed priority (highest index first) or round-robin with a persistent pointer.
- Used wherever a multi-hot status word must be serialised into a stream of indices (interrupt/event servicing).

Parameters:
- N, 8, width of the request vector; must be ≥ 2.
- W, $clog2(N), width of the index output; derived, not to be overridden.
- MODE, 0, ordering: 0 = fixed priority, highest index first; 1 = round-robin, ascending from the pointer with wrap.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_i  input  N  request vector; sampled on accept.
- req_valid_i  input  1  req_i is valid.
- req_ready_o  output  1  block can accept a vector (registered).
- idx_o  output  W  index of the current set bit.
- out_valid_o  output  1  idx_o is valid.
- out_ready_i  input  1  downstream consumes idx_o.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values (rst_n low at a clk edge):
  - state=IDLE, pending=0, rr_ptr=0.
  - req_ready_o=0, out_valid_o=0, idx_o=0.
  - First edge with rst_n high: req_ready_o goes to 1.
- States:
  - IDLE: req_ready_o=1, out_valid_o=0.
  - SCAN: req_ready_o=0, out_valid_o=1.
- Accept: req_valid_i && req_ready_o at an edge.
  - Nonzero req_i: pending<=req_i, idx_o<=first index per MODE, out_valid_o<=1, req_ready_o<=0, state<=SCAN.
  - Latency: first index is valid the cycle after accept.
  - req_i==0: vector is discarded; state stays IDLE, req_ready_o stays 1, no output.
- Emit: out_valid_o && out_ready_i at an edge clears bit idx_o in pending.
  - Bits remain: idx_o<=next index from the updated pending; out_valid_o stays 1. Throughput is one index per cycle under continuous out_ready_i.
  - Last bit: out_valid_o<=0, req_ready_o<=1, state<=IDLE.
  - No new vector is accepted in the same cycle as the last emit; the minimum gap is one cycle.
- Stall: while out_valid_o=1 and out_ready_i=0, idx_o and pending hold stable.
- Back-pressure on input: req_valid_i is ignored while req_ready_o=0. Nothing is captured and nothing is queued.
- MODE 0 ordering: highest set index of pending. Example: 8'b1000_0001 -> 7, then 0.
- MODE 1 ordering:
  - Selects the lowest set index ≥ rr_ptr; if none, wraps and selects the lowest set index overall.
  - On each emit handshake, rr_ptr<=(idx_o+1) mod N. N not a power of 2 must wrap to 0 correctly.
  - rr_ptr persists across vectors and is cleared only by reset.
- Index select: a combinational scan over pending, no priority-encoder chains wider than N.
- idx_o is registered; its value is don't-care when out_valid_o=0 but holds the last value (not X).
- Reset mid-SCAN: pending cleared; out_valid_o=0 at that edge. No further indices are produced from the aborted vector.
- All-ones vector: exactly N emits, with no missed or duplicated index.

Optional Feature:
- Macro: PRIO_BITSCAN_LAST_EN.
- Defined:
  - Adds output port last_o (1 bit), registered, reset 0.
  - last_o=1 together with out_valid_o when idx_o is the final set bit of the current vector (pending has exactly one bit set).
  - last_o follows the same hold/stall rules as idx_o.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then single bits (N=8, MODE=0, out_ready_i=1): accept 8'b0000_0001, 8'b0000_0100, 8'b0100_0000, 8'b1000_0000 in turn -> idx_o = 0, 2, 6, 7, each valid one cycle after accept. req_ready_o returns to 1 the cycle after each emit.
- Multi-hot fixed priority (MODE=0): accept 8'b1010_0101 -> idx_o sequence 7, 5, 2, 0 on consecutive cycles. With the macro defined, last_o=1 only on 0.
- Stall and input back-pressure: accept 8'b0001_1000 with out_ready_i=0 for 3 cycles -> idx_o=4 held for all 3 cycles.
  - Asserting req_valid_i with 8'hFF during the stall is ignored.
  - Raising out_ready_i then gives 4, 3, then IDLE.
- Zero vector: accept 8'h00 -> out_valid_o stays 0, req_ready_o stays 1.
- Round-robin (MODE=1), from reset:
  - Accept 8'b1000_0011 -> emits 0, 1, 7; rr_ptr ends at 0.
  - Next accept 8'b0000_1100 -> emits 2, 3; rr_ptr ends at 4.
  - Next accept 8'b0000_0110 -> emits 1, 2 (wrap from 4).
- Reset mid-operation: accept 8'hFF, emit 7 and 6, assert rst_n=0 for one edge -> out_valid_o=0 and req_ready_o=0 that cycle, req_ready_o=1 the cycle after release. No further indices from the aborted vector.

Source files
------------

// File: rtl/prio_bitscan_enc.sv
// prio_bitscan_enc: serialises a multi-hot request vector into a stream of set-bit indices.
// Optional macro PRIO_BITSCAN_LAST_EN adds last_o marking the final index of each vector.
module prio_bitscan_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    output logic [W-1:0] idx_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
`ifdef PRIO_BITSCAN_LAST_EN
    ,
    output logic         last_o
`endif
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state;
    logic [N-1:0] pending, nxt_pend;
    logic [W-1:0] rr_ptr, nxt_ptr, first_idx, nxt_idx;
    // MODE 0 takes the highest set bit; MODE 1 the lowest at/after p, else the lowest overall
    function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] p);
        logic [W-1:0] lo, hi, top;
        logic hit;
        lo = '0;
        hi = '0;
        top = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lo = W'(i);
            if (v[i] && W'(i) >= p) begin
                hi = W'(i);
                hit = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) if (v[i]) top = W'(i);
        return MODE == 0 ? top : (hit ? hi : lo);
    endfunction
    assign nxt_pend = pending & ~(N'(1) << idx_o);
    assign nxt_ptr = idx_o == W'(N - 1) ? '0 : idx_o + 1'b1;
    assign first_idx = pick(req_i, rr_ptr);
    assign nxt_idx = pick(nxt_pend, nxt_ptr);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pending <= '0;
            rr_ptr <= '0;
            req_ready_o <= 1'b0;
            out_valid_o <= 1'b0;
            idx_o <= '0;
`ifdef PRIO_BITSCAN_LAST_EN
            last_o <= 1'b0;
`endif
        end else if (state == IDLE) begin
            req_ready_o <= 1'b1;
            if (req_valid_i && req_ready_o && |req_i) begin
                pending <= req_i;
                idx_o <= first_idx;
                out_valid_o <= 1'b1;
                req_ready_o <= 1'b0;
                state <= SCAN;
`ifdef PRIO_BITSCAN_LAST_EN
                last_o <= $onehot(req_i);
`endif
            end
        end else if (out_ready_i) begin
            pending <= nxt_pend;
            rr_ptr <= nxt_ptr;
            if (|nxt_pend) begin
                idx_o <= nxt_idx;
`ifdef PRIO_BITSCAN_LAST_EN
                last_o <= $onehot(nxt_pend);
`endif
            end else begin
                out_valid_o <= 1'b0;
                req_ready_o <= 1'b1;
                state <= IDLE;
`ifdef PRIO_BITSCAN_LAST_EN
                last_o <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_prio_bitscan_enc.sv
// tb_prio_bitscan_enc: drives a fixed-priority and a round-robin instance with identical
// stimulus and scoreboards each index stream against a circular-walk reference.
module tb_prio_bitscan_enc;
    localparam int N = 8;
    localparam int W = 3;
    logic clk = 1'b0, rst_n = 1'b0, req_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [N-1:0] req_i = '0;
    logic rdy0, rdy1, ov0, ov1, last0, last1;
    logic [W-1:0] idx0, idx1;
    int total = 0, bad = 0, rr = 0;
    bit rnd = 0;
    int q0[$], q1[$];
    bit ql0[$], ql1[$];

    always #5 clk = ~clk;

    prio_bitscan_enc #(.N(N), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_valid_i(req_valid_i),
        .req_ready_o(rdy0), .idx_o(idx0), .out_valid_o(ov0), .out_ready_i(out_ready_i)
`ifdef PRIO_BITSCAN_LAST_EN
        , .last_o(last0)
`endif
    );
    prio_bitscan_enc #(.N(N), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_valid_i(req_valid_i),
        .req_ready_o(rdy1), .idx_o(idx1), .out_valid_o(ov1), .out_ready_i(out_ready_i)
`ifdef PRIO_BITSCAN_LAST_EN
        , .last_o(last1)
`endif
    );
`ifndef PRIO_BITSCAN_LAST_EN
    assign last0 = 1'b0;
    assign last1 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    // Reference: fixed priority walks downwards; round-robin walks circularly upward from rr
    task automatic push(input logic [N-1:0] v);
        int last;
        if (v == 0) return;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) begin
                q0.push_back(i);
                ql0.push_back(0);
            end
        ql0[ql0.size() - 1] = 1;
        last = rr;
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) begin
                q1.push_back((rr + k) % N);
                ql1.push_back(0);
                last = (rr + k) % N;
            end
        ql1[ql1.size() - 1] = 1;
        rr = (last + 1) % N;
    endtask

    always @(negedge clk)
        if (rst_n) begin
            if (ov0) begin
                if (q0.size() == 0) chk("spurious_valid0", ov0, 0);
                else begin
                    chk("idx0", idx0, q0[0]);
`ifdef PRIO_BITSCAN_LAST_EN
                    chk("last0", last0, ql0[0]);
`endif
                    if (out_ready_i) begin
                        void'(q0.pop_front());
                        void'(ql0.pop_front());
                    end
                end
            end
            if (ov1) begin
                if (q1.size() == 0) chk("spurious_valid1", ov1, 0);
                else begin
                    chk("idx1", idx1, q1[0]);
`ifdef PRIO_BITSCAN_LAST_EN
                    chk("last1", last1, ql1[0]);
`endif
                    if (out_ready_i) begin
                        void'(q1.pop_front());
                        void'(ql1.pop_front());
                    end
                end
            end
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] v);
        int n = 0;
        while (!rdy0 && n < 200) begin
            if (rnd) begin
                out_ready_i = $urandom_range(0, 3) != 0;
                req_valid_i = $urandom_range(0, 1) == 1;
                req_i = N'($urandom);
            end
            step();
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        chk("rdy_match", rdy1, rdy0);
        req_i = v;
        req_valid_i = 1'b1;
        push(v);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov0 || ov1 || !rdy0) && n < 300) begin
            if (rnd) out_ready_i = $urandom_range(0, 3) != 0;
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", n, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        ql0.delete();
        ql1.delete();
        rr = 0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic exp_seq(input bit d, input int e[4], input int n);
        for (int i = 0; i < n; i++) begin
            chk(d ? "seq_ov1" : "seq_ov0", d ? ov1 : ov0, 1);
            chk(d ? "seq_idx1" : "seq_idx0", d ? idx1 : idx0, e[i]);
            step();
        end
        chk(d ? "seq_end1" : "seq_end0", d ? ov1 : ov0, 0);
        chk("seq_ready", rdy0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] singles[4] = '{8'b0000_0001, 8'b0000_0100, 8'b0100_0000, 8'b1000_0000};
        int sidx[4] = '{0, 2, 6, 7};
        step();
        step();
        chk("rst_ready", rdy0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_idx", idx0, 0);
        chk("rst_ready1", rdy1, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", rdy0, 1);
        chk("post_rst_ready1", rdy1, 1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(singles[i]);
            exp_seq(0, '{sidx[i], 0, 0, 0}, 1);
        end
        send(8'b1010_0101);
        exp_seq(0, '{7, 5, 2, 0}, 4);
        out_ready_i = 1'b0;
        send(8'b0001_1000);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", ov0, 1);
            chk("stall_idx", idx0, 4);
            chk("stall_ready", rdy0, 0);
            if (i == 1) begin
                req_i = 8'hFF;
                req_valid_i = 1'b1;
            end
            step();
        end
        req_valid_i = 1'b0;
        out_ready_i = 1'b1;
        exp_seq(0, '{4, 3, 0, 0}, 2);
        send(8'h00);
        chk("zero_valid", ov0, 0);
        chk("zero_ready", rdy0, 1);
        step();
        chk("zero_valid_b", ov0, 0);
        reset_dut();
        send(8'b1000_0011);
        exp_seq(1, '{0, 1, 7, 0}, 3);
        send(8'b0000_1100);
        exp_seq(1, '{2, 3, 0, 0}, 2);
        send(8'b0000_0110);
        exp_seq(1, '{1, 2, 0, 0}, 2);
        send(8'hFF);
        step();
        step();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        ql0.delete();
        ql1.delete();
        rr = 0;
        step();
        chk("midrst_valid", ov0, 0);
        chk("midrst_ready", rdy0, 0);
        chk("midrst_valid1", ov1, 0);
        rst_n = 1'b1;
        step();
        chk("midrst_release_ready", rdy0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_quiet", ov0 | ov1, 0);
            step();
        end
        rnd = 1;
        for (int i = 0; i < 150; i++) begin
            v = $urandom_range(0, 3) == 0 ? N'(1) << $urandom_range(0, N - 1) : N'($urandom);
            if ($urandom_range(0, 9) == 0) v = '0;
            if ($urandom_range(0, 9) == 0) v = '1;
            send(v);
        end
        drain();
        chk("final_q0", q0.size(), 0);
        chk("final_q1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
